// File: rtl/tick_timer_pkg.sv
// Shared types and defaults for the tick timeout timer.
// Holds the controller state enum and the default counter width.
package tick_timer_pkg;

  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } tmr_state_e;

endpackage

// File: rtl/tick_timeout_timer.sv
// Tick-driven timeout timer: counts timebase strobes up to a latched limit, one-shot or auto-reload.
// Optional pause input and PAUSED state are enabled by defining TICK_TIMER_PAUSE_EN.
//
// state  | meaning
// IDLE   | not counting; ticks ignored, waiting for start_i
// RUN    | counting ticks toward limit_q
// PAUSED | count held, ticks ignored until pause_i drops (TICK_TIMER_PAUSE_EN only)
module tick_timeout_timer
  import tick_timer_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int PERIODIC_DEF = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             periodic_i,
  input  logic [CNT_W-1:0] limit_i,
`ifdef TICK_TIMER_PAUSE_EN
  input  logic             pause_i,
`endif
  output logic             timeout_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] count_o
);

  tmr_state_e       state_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] limit_q;
  logic             periodic_q;
  logic             timeout_q;
  logic [CNT_W-1:0] count_inc;
  logic             pause_w;

`ifdef TICK_TIMER_PAUSE_EN
  assign pause_w = pause_i;
`else
  assign pause_w = 1'b0;
`endif

  // count_q stays below limit_q, so the increment never wraps
  assign count_inc = count_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      limit_q    <= '0;
      periodic_q <= (PERIODIC_DEF != 0);
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (abort_i) begin
        state_q <= IDLE;
        count_q <= '0;
      end else if (start_i) begin
        // a zero limit would never expire, so treat it as one tick
        limit_q    <= (limit_i == '0) ? CNT_W'(1) : limit_i;
        periodic_q <= periodic_i;
        count_q    <= '0;
        state_q    <= RUN;
      end else begin
        case (state_q)
          RUN: begin
            if (pause_w) begin
              state_q <= PAUSED;
            end else if (tick_i) begin
              if (count_inc == limit_q) begin
                count_q   <= '0;
                timeout_q <= 1'b1;
                state_q   <= periodic_q ? RUN : IDLE;
              end else begin
                count_q <= count_inc;
              end
            end
          end
          PAUSED: begin
            if (!pause_w) state_q <= RUN;
          end
          default: ;
        endcase
      end
    end
  end

  assign timeout_o = timeout_q;
  assign busy_o    = (state_q != IDLE);
  assign count_o   = count_q;

endmodule

// File: doc/tick_timeout_timer.md
TICK_TIMEOUT_TIMER -- requirements
Module: tick_timeout_timer

Interface
REQ-001 Parameter CNT_W, default 8, width of the tick counter and of the limit.
REQ-002 Parameter PERIODIC_DEF, default 0, sets periodic mode when periodic_i is tied to the default constant.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 tick_i  input  1  one-cycle timebase strobe, e.g. 100 ms.
REQ-006 start_i  input  1  load limit and begin or restart counting.
REQ-007 abort_i  input  1  stop counting without a timeout.
REQ-008 periodic_i  input  1  sampled at start: 1 = auto-reload, 0 = one-shot.
REQ-009 limit_i  input  CNT_W  number of ticks per timeout; sampled only on an accepted start.
REQ-010 timeout_o  output  1  registered one-cycle pulse on expiry.
REQ-011 busy_o  output  1  high while in RUN or PAUSED.
REQ-012 count_o  output  CNT_W  ticks counted in the current period.

Function
REQ-013 States: IDLE, RUN, PAUSED (PAUSED exists only with the macro in REQ-026).
REQ-014 Priority within a cycle: abort_i, then start_i, then pause (REQ-026), then tick_i.
REQ-015 IDLE + start_i: latch limit_q = limit_i (value 0 is latched as 1); latch periodic_q; count = 0; go to RUN.
REQ-016 RUN + tick_i: if count+1 == limit_q, then count = 0 and timeout_o = 1 in the next cycle; the state becomes RUN if periodic_q is set, otherwise IDLE. Else count = count+1.
REQ-017 Latency: timeout_o is high exactly one cycle after the clock edge that samples the terminal tick_i; busy_o drops on that same edge in one-shot mode.
REQ-018 start_i in RUN or PAUSED: reload limit_q and periodic_q, count = 0, go to RUN; a tick_i in the same cycle is ignored; no timeout pulse.
REQ-019 abort_i in any state: count = 0, go to IDLE; no timeout pulse, even if a terminal tick_i occurs in the same cycle.
REQ-020 tick_i in IDLE: ignored.
REQ-021 Counter arithmetic is unsigned, CNT_W bits; count never exceeds limit_q-1, so it never wraps.
REQ-022 Back-to-back ticks on consecutive cycles are each counted; limit_q = 1 with continuous ticks in periodic mode gives timeout_o high every cycle.

Reset
REQ-023 On rst = 0 at a clock edge: state = IDLE, count_o = 0, limit_q = 0, periodic_q = 0, timeout_o = 0, busy_o = 0.
REQ-024 Reset in mid-count discards the period and raises no pulse; reset overrides all inputs.
REQ-025 The first cycle after reset is released accepts start_i normally.

Configuration
REQ-026 Macro TICK_TIMER_PAUSE_EN defined: adds input port pause_i (1 bit). In RUN with pause_i = 1, the state goes to PAUSED and tick_i is ignored. In PAUSED with pause_i = 0, the state returns to RUN with count kept. abort_i and start_i act in PAUSED as specified.
REQ-027 Macro not defined: pause_i port and PAUSED state are absent; behaviour is otherwise identical.

Structure
REQ-028 Shared package tick_timer_pkg holds the state enum typedef (IDLE, RUN, PAUSED) and the default CNT_W constant.
REQ-029 Single module; no sub-module. Next-state logic and registers are in one block; timeout_o comes directly from a flop.

Verification
REQ-030 One-shot: limit 5, ticks every 3 cycles -> count_o 1..4, one timeout_o pulse one cycle after the 5th tick, then busy_o = 0.
REQ-031 Periodic: limit 3, 9 ticks -> exactly 3 timeout_o pulses; count_o sequence 1,2,0,1,2,0,1,2,0; busy_o stays 1.
REQ-032 abort_i and terminal tick_i in the same cycle (limit 2) -> no pulse, IDLE, count_o = 0.
REQ-033 start_i with limit 4 at count 3 of limit 5 -> count_o = 0; timeout_o only after 4 further ticks.
REQ-034 rst low at count 2 -> all outputs 0; subsequent ticks ignored until start_i.
REQ-035 With TICK_TIMER_PAUSE_EN: limit 3, pause_i high during 2 ticks -> count_o held; the timeout arrives after 3 unpaused ticks. limit_i = 0 -> timeout on the first tick.
